mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin scheduler that shares one pipelined signed 8x8 `Multiplier` instance among `NUM_REQ` requesters. It issues at most one operand pair per cycle into the multiplier and tags each pair with its requester index. It then returns each 24-bit product to the right requester on a common response bus. It sits between the DSP clients and the single multiplier instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `MUL_LAT`, 2, multiplier latency in cycles, from `mul_a`/`mul_b` being driven to the matching `mul_out` (1..8).
- `clk` input 1: clock. All logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: request pending, one bit per requester.
- `req_a` input `8*NUM_REQ`: signed operand A. Requester i uses bits [8i+7:8i].
- `req_b` input `8*NUM_REQ`: signed operand B, same packing as `req_a`.
- `req_clr` input `NUM_REQ`: clear accumulator with this request. Ignored unless `MULT_ARB_ACC_EN` is defined.
- `req_ready` output `NUM_REQ`: one-hot grant. Combinational from `req_valid` and the arbitration pointer.
- `hold` input 1: when 1, no grants are issued. In-flight operations still complete.
- `mul_a` output 8: operand A to the multiplier, registered.
- `mul_b` output 8: operand B to the multiplier, registered.
- `mul_out` input 24: product from the multiplier.
- `rsp_valid` output 1: one-cycle pulse, response present.
- `rsp_id` output `$clog2(NUM_REQ)`: index of the requester that owns the response.
- `rsp_data` output 24: product, or the accumulated value when `MULT_ARB_ACC_EN` is defined.

## Operation
- **Arbitration:**
  - Round-robin pointer `ptr`, reset to 0.
  - Each cycle with `hold`=0, grant the first i with `req_valid[i]`=1, searching `ptr`, `ptr+1`, … modulo `NUM_REQ`.
  - A handshake completes when `req_valid[i]` & `req_ready[i]`.
  - On a grant, `ptr` becomes (granted+1) mod `NUM_REQ`. With no grant, `ptr` holds.
- **Request rules:**
  - Operands are sampled on the handshake cycle.
  - A requester must hold `req_valid`, `req_a` and `req_b` stable until granted.
- **Issue stage:**
  - On a handshake, register the operands into `mul_a`/`mul_b`.
  - Push the tag {valid=1, id, clr} into a `MUL_LAT`-deep shift register.
  - With no handshake, `mul_a`/`mul_b` hold their last value and a tag with valid=0 is pushed.
- **Retire stage:**
  - When the tag leaving the shift register is valid, register `rsp_valid`=1, `rsp_id`=tag id, and `rsp_data` = `mul_out` (or the accumulator result).
  - Responses return in grant order.
  - There is no response back-pressure. Consumers must accept every pulse.
- **Arithmetic:**
  - Operands are two's complement.
  - The product is sign-extended to 24 bits by the multiplier and passed through unchanged.
- **Reset values:**
  - `mul_a`=0, `mul_b`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - All tags invalid, `ptr`=0.
  - Accumulators = 0.
- **Reset mid-operation:** all in-flight tags are discarded, so no responses follow the reset. The first grant after release goes to the lowest valid index.

## Timing
- Handshake at edge t.
- `mul_a`/`mul_b` valid after edge t.
- `mul_out` valid `MUL_LAT` cycles later.
- `rsp_valid` asserted after edge t+1+`MUL_LAT`. With the default this is 3 cycles from handshake to response.
- Throughput is one operation per cycle when requests are back-to-back, with no bubbles.
- `hold` asserted in cycle t: no grant in cycle t, and `req_ready`=0 combinationally.
- A single active requester is granted every cycle.

## Configuration
- `MULT_ARB_ACC_EN` defined:
  - One 24-bit signed accumulator per requester.
  - At retire: `acc[id]` = (clr ? 0 : `acc[id]`) + `mul_out`, wrapping modulo 2^24.
  - `rsp_data` = the new `acc[id]`.
  - Accumulators reset to 0.
- `MULT_ARB_ACC_EN` undefined:
  - No accumulators are built and `req_clr` is ignored.
  - `rsp_data` = `mul_out`.

## Test plan
- **Single request after reset:** requester 0 sends A=99, B=-50. Expect `rsp_valid` 3 cycles after the handshake, `rsp_id`=0, `rsp_data`=0xFFECAA (-4950).
- **Simultaneous requests:** all 4 requesters assert together with A=72, B=-127 / A=-43, B=9 / A=88, B=-66 / A=-81, B=-102.
  - Grants go in order 0,1,2,3 on consecutive cycles.
  - Responses are 0xFFDC48, 0xFFFE7D, 0xFFE950, 0x002046 with ids 0..3, back-to-back.
- **Round-robin fairness:** requesters 1 and 3 hold `req_valid` continuously. Grants alternate 1,3,1,3, and `ptr` wraps from 0 correctly.
- **Hold:** assert `hold` for 5 cycles while requests are pending.
  - No grants during `hold`.
  - Pending responses still emerge.
  - Grants resume on the cycle `hold` drops.
- **Reset mid-operation:** pulse `rst` with 2 operations in flight. No `rsp_valid` follows, and all outputs read their reset values.
- **Accumulation (`MULT_ARB_ACC_EN`):** requester 2 sends 99×-50 with clr=1, then 72×-127 with clr=0.
  - Responses are 0xFFECAA, then 0xFFC8F2 (-14094).
  - A following clr=1 request with 1×1 returns 0x000001.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pipelined signed 8x8 multiplier.
// Optional per-requester accumulators are built when MULT_ARB_ACC_EN is defined.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_clr,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 hold,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [23:0]          mul_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [23:0]          rsp_data
);

    logic [IDW-1:0] ptr;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] ptr_next;

    // issue-register tag, travels alongside mul_a/mul_b
    logic           iss_v;
    logic [IDW-1:0] iss_id;
    logic           iss_clr;

    // latency-matching tag pipe, tail lines up with mul_out
    logic           tag_v   [MUL_LAT];
    logic [IDW-1:0] tag_id  [MUL_LAT];
    logic           tag_clr [MUL_LAT];

    logic           tail_v;
    logic [IDW-1:0] tail_id;
    logic           tail_clr;

    assign tail_v   = tag_v[MUL_LAT-1];
    assign tail_id  = tag_id[MUL_LAT-1];
    assign tail_clr = tag_clr[MUL_LAT-1];

    // search from ptr for the first pending requester, unless held
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!hold && !gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(j);
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // pointer moves one past the winner, wrapping at NUM_REQ
    always_comb begin
        if (gnt_idx == IDW'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + IDW'(1);
        end
    end

    // issue stage: capture operands and tag on a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            iss_v   <= 1'b0;
            iss_id  <= '0;
            iss_clr <= 1'b0;
        end else begin
            iss_v <= gnt_found;
            if (gnt_found) begin
                ptr     <= ptr_next;
                mul_a   <= req_a[8*int'(gnt_idx) +: 8];
                mul_b   <= req_b[8*int'(gnt_idx) +: 8];
                iss_id  <= gnt_idx;
                iss_clr <= req_clr[gnt_idx];
            end
        end
    end

    // tag pipe shifts every cycle so bubbles stay aligned with the multiplier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_v[k]   <= 1'b0;
                tag_id[k]  <= '0;
                tag_clr[k] <= 1'b0;
            end
        end else begin
            tag_v[0]   <= iss_v;
            tag_id[0]  <= iss_id;
            tag_clr[0] <= iss_clr;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_id[k]  <= tag_id[k-1];
                tag_clr[k] <= tag_clr[k-1];
            end
        end
    end

`ifdef MULT_ARB_ACC_EN

    logic [23:0] acc [NUM_REQ];
    logic [23:0] acc_sum;

    // clear-then-add for the retiring requester, wraps mod 2^24
    always_comb begin
        acc_sum = (tail_clr ? 24'd0 : acc[tail_id]) + mul_out;
    end

    // retire stage: update accumulator and report its new value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                acc[k] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tail_v;
            if (tail_v) begin
                acc[tail_id] <= acc_sum;
                rsp_id       <= tail_id;
                rsp_data     <= acc_sum;
            end
        end
    end

`else

    // clear flags only matter with accumulators present
    logic unused_clr;
    assign unused_clr = tail_clr;

    // retire stage: pass the product straight through
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tail_v;
            if (tail_v) begin
                rsp_id   <= tail_id;
                rsp_data <= mul_out;
            end
        end
    end

`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed checks of grant order, hold, reset and responses.
// A two-stage signed multiplier model stands in for the shared multiplier.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_clr = '0;
    logic [3:0]  req_ready;
    logic        hold = 1'b0;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [23:0] mul_out;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [23:0] rsp_data;

    int vecs = 0;
    int errs = 0;

    mult_arbiter #(.NUM_REQ(4), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_clr(req_clr), .req_ready(req_ready), .hold(hold),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    logic signed [15:0] prod;
    logic [23:0] p1 = '0;
    logic [23:0] p2 = '0;
    assign prod = $signed(mul_a) * $signed(mul_b);
    always @(posedge clk) begin
        p1 <= {{8{prod[15]}}, prod};
        p2 <= p1;
    end
    assign mul_out = p2;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        req_clr = '0;
        hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vecs++;
        if ({mul_a, mul_b, rsp_valid, rsp_id, rsp_data} !== 43'd0) begin
            errs++;
            $display("FAIL reset_outputs got %h want 0",
                     {mul_a, mul_b, rsp_valid, rsp_id, rsp_data});
        end
    endtask

    task automatic test_single();
        logic ev;
        do_reset();
        req_a[7:0] = 8'd99;
        req_b[7:0] = 8'hCE;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 4'b0001;
            else req_valid = 4'b0000;
            #1;
            if (c == 0) begin
                vecs++;
                if (req_ready !== 4'b0001) begin
                    errs++;
                    $display("FAIL single_ready got %b want 0001", req_ready);
                end
            end
            if (c == 1) begin
                vecs++;
                if ({mul_a, mul_b} !== 16'h63CE) begin
                    errs++;
                    $display("FAIL single_opnd got %h want 63ce", {mul_a, mul_b});
                end
            end
            ev = (c == 4);
            vecs++;
            if (rsp_valid !== ev) begin
                errs++;
                $display("FAIL single_rsp_valid c=%0d got %b want %b", c, rsp_valid, ev);
            end
            if (ev) begin
                vecs++;
                if ({rsp_id, rsp_data} !== {2'd0, 24'hFFECAA}) begin
                    errs++;
                    $display("FAIL single_rsp got %h want 0ffecaa", {rsp_id, rsp_data});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] ta [4] = '{8'd72, 8'hD5, 8'd88, 8'hAF};
        logic [7:0] tb [4] = '{8'h81, 8'd9, 8'hBE, 8'h9A};
        logic [23:0] ed [4] = '{24'hFFDC48, 24'hFFFE7D, 24'hFFE950, 24'h002046};
        logic [3:0] er;
        logic ev;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8] = ta[i];
            req_b[8*i +: 8] = tb[i];
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 4'hF;
            else if (c <= 4) req_valid[c-1] = 1'b0;
            #1;
            er = (c < 4) ? 4'(1 << c) : 4'h0;
            vecs++;
            if (req_ready !== er) begin
                errs++;
                $display("FAIL simul_ready c=%0d got %b want %b", c, req_ready, er);
            end
            ev = (c >= 4 && c <= 7);
            vecs++;
            if (rsp_valid !== ev) begin
                errs++;
                $display("FAIL simul_rsp_valid c=%0d got %b want %b", c, rsp_valid, ev);
            end
            if (ev) begin
                vecs++;
                if ({rsp_id, rsp_data} !== {2'(c-4), ed[c-4]}) begin
                    errs++;
                    $display("FAIL simul_rsp c=%0d got %h want %h",
                             c, {rsp_id, rsp_data}, {2'(c-4), ed[c-4]});
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] er;
        logic ev;
        logic [1:0] eid;
        logic [23:0] ed;
        do_reset();
        req_a[15:8]  = 8'd3;
        req_b[15:8]  = 8'd5;
        req_a[31:24] = 8'hFE;
        req_b[31:24] = 8'd7;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 4'b1010;
            if (c == 8) req_valid = 4'b0000;
            #1;
            er = (c >= 8) ? 4'b0000 : ((c % 2 == 0) ? 4'b0010 : 4'b1000);
            vecs++;
            if (req_ready !== er) begin
                errs++;
                $display("FAIL rr_ready c=%0d got %b want %b", c, req_ready, er);
            end
            ev = (c >= 4);
            vecs++;
            if (rsp_valid !== ev) begin
                errs++;
                $display("FAIL rr_rsp_valid c=%0d got %b want %b", c, rsp_valid, ev);
            end
            if (ev) begin
                eid = (c % 2 == 0) ? 2'd1 : 2'd3;
                ed  = (c % 2 == 0) ? 24'h00000F : 24'hFFFFF2;
                vecs++;
                if ({rsp_id, rsp_data} !== {eid, ed}) begin
                    errs++;
                    $display("FAIL rr_rsp c=%0d got %h want %h", c, {rsp_id, rsp_data}, {eid, ed});
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] er;
        logic ev;
        logic [25:0] ex;
        do_reset();
        req_a[7:0]  = 8'd10;
        req_b[7:0]  = 8'hFD;
        req_a[15:8] = 8'h80;
        req_b[15:8] = 8'h80;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 4'b0011;
            if (c == 1) begin
                req_valid[0] = 1'b0;
                hold = 1'b1;
            end
            if (c == 6) hold = 1'b0;
            if (c == 7) req_valid[1] = 1'b0;
            #1;
            er = (c == 0) ? 4'b0001 : ((c == 6) ? 4'b0010 : 4'b0000);
            vecs++;
            if (req_ready !== er) begin
                errs++;
                $display("FAIL hold_ready c=%0d got %b want %b", c, req_ready, er);
            end
            if (c >= 2 && c <= 5) begin
                vecs++;
                if ({mul_a, mul_b} !== 16'h0AFD) begin
                    errs++;
                    $display("FAIL hold_opnd c=%0d got %h want 0afd", c, {mul_a, mul_b});
                end
            end
            ev = (c == 4 || c == 10);
            vecs++;
            if (rsp_valid !== ev) begin
                errs++;
                $display("FAIL hold_rsp_valid c=%0d got %b want %b", c, rsp_valid, ev);
            end
            if (ev) begin
                ex = (c == 4) ? {2'd0, 24'hFFFFE2} : {2'd1, 24'h004000};
                vecs++;
                if ({rsp_id, rsp_data} !== ex) begin
                    errs++;
                    $display("FAIL hold_rsp c=%0d got %h want %h", c, {rsp_id, rsp_data}, ex);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] ed [3];
        logic ev;
`ifdef MULT_ARB_ACC_EN
        ed = '{24'hFFECAA, 24'hFFC8F2, 24'h000001};
`else
        ed = '{24'hFFECAA, 24'hFFDC48, 24'h000001};
`endif
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 4'b0100;
                req_a[23:16] = 8'd99;
                req_b[23:16] = 8'hCE;
                req_clr = 4'b0100;
            end
            if (c == 1) begin
                req_a[23:16] = 8'd72;
                req_b[23:16] = 8'h81;
                req_clr = 4'b0000;
            end
            if (c == 2) begin
                req_a[23:16] = 8'd1;
                req_b[23:16] = 8'd1;
                req_clr = 4'b0100;
            end
            if (c == 3) begin
                req_valid = 4'b0000;
                req_clr = 4'b0000;
            end
            #1;
            if (c < 4) begin
                vecs++;
                if (req_ready !== ((c < 3) ? 4'b0100 : 4'b0000)) begin
                    errs++;
                    $display("FAIL b2b_ready c=%0d got %b", c, req_ready);
                end
            end
            if (c == 1) begin
                vecs++;
                if ({mul_a, mul_b} !== 16'h63CE) begin
                    errs++;
                    $display("FAIL b2b_opnd got %h want 63ce", {mul_a, mul_b});
                end
            end
            ev = (c >= 4 && c <= 6);
            vecs++;
            if (rsp_valid !== ev) begin
                errs++;
                $display("FAIL b2b_rsp_valid c=%0d got %b want %b", c, rsp_valid, ev);
            end
            if (ev) begin
                vecs++;
                if ({rsp_id, rsp_data} !== {2'd2, ed[c-4]}) begin
                    errs++;
                    $display("FAIL b2b_rsp c=%0d got %h want %h",
                             c, {rsp_id, rsp_data}, {2'd2, ed[c-4]});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a[7:0]  = 8'd5;
        req_b[7:0]  = 8'd6;
        req_a[15:8] = 8'd7;
        req_b[15:8] = 8'd8;
        req_a[31:24] = 8'd2;
        req_b[31:24] = 8'd2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 4'b0011;
            if (c == 1) req_valid = 4'b0010;
            if (c == 2) begin
                req_valid = 4'b0000;
                rst = 1'b1;
            end
            if (c == 3) rst = 1'b0;
            if (c == 8) req_valid = 4'b1010;
            if (c == 9) req_valid = 4'b0000;
            #1;
            if (c == 1) begin
                vecs++;
                if (req_ready !== 4'b0010) begin
                    errs++;
                    $display("FAIL rmid_ready1 got %b want 0010", req_ready);
                end
            end
            if (c == 2) begin
                vecs++;
                if ({mul_a, mul_b, rsp_valid, rsp_id, rsp_data} !== 43'd0) begin
                    errs++;
                    $display("FAIL rmid_outputs got %h want 0",
                             {mul_a, mul_b, rsp_valid, rsp_id, rsp_data});
                end
            end
            if (c >= 3 && c <= 8) begin
                vecs++;
                if (rsp_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL rmid_rsp_valid c=%0d got %b want 0", c, rsp_valid);
                end
            end
            if (c == 8) begin
                vecs++;
                if (req_ready !== 4'b0010) begin
                    errs++;
                    $display("FAIL rmid_first_grant got %b want 0010", req_ready);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
